// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
// Packs R-type / lw / sw / beq instruction fields into 32-bit MIPS words and
// writes them sequentially into instruction memory. Used to preload test
// programs before the processor runs.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             synchronous restart of pointer, count and err_full
//   in_valid/in_ready request handshake
//   in_kind           00 R-type, 01 lw, 10 sw, 11 beq
//   in_rs .. in_imm   instruction fields
//   mem_we/mem_ack    write strobe, held until acknowledged
//   mem_addr          BASE_ADDR + ptr (wraps modulo 2^ADDR_W)
//   mem_wdata         encoded instruction
//   count, full       words written since reset/clear, count == MAX_WORDS
//   err_full          sticky: request seen while full
module mips_instr_encoder #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned MAX_WORDS = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_kind,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [5:0]        in_funct,
   input  logic [15:0]       in_imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err_full
);

   localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   MAX_CNT = (ADDR_W+1)'(MAX_WORDS);
   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic {IDLE, WRITE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] ptr;
   logic              clr_pend;
   logic [31:0]       enc;
   logic              accept;
   logic              done;

   always_comb begin
      enc = '0;
      case (in_kind)
         2'b00:   enc = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
         2'b01:   enc = {6'b100011, in_rs, in_rt, in_imm};
         2'b10:   enc = {6'b101011, in_rs, in_rt, in_imm};
         default: enc = {6'b000100, in_rs, in_rt, in_imm};
      endcase
   end

   assign full     = (count == MAX_CNT);
   assign mem_addr = BASE + ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      mem_we    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !full && !clear;
            if (in_valid && !full && !clear) state_nxt = WRITE;
         end
         WRITE: begin
            mem_we = 1'b1;
            if (mem_ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = (state == IDLE) && in_valid && in_ready;
   assign done   = (state == WRITE) && mem_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         count     <= '0;
         err_full  <= 1'b0;
         clr_pend  <= 1'b0;
         mem_wdata <= '0;
      end else begin
         if (accept) mem_wdata <= enc;
         if (in_valid && full) err_full <= 1'b1;
         if (state == IDLE && clear) begin
            ptr      <= '0;
            count    <= '0;
            err_full <= 1'b0;
         end
         // A clear during WRITE is deferred so the in-flight word still lands;
         // it then takes effect at the ack edge instead of the increment.
         if (state == WRITE && clear) clr_pend <= 1'b1;
         if (done) begin
            clr_pend <= 1'b0;
            if (clr_pend || clear) begin
               ptr      <= '0;
               count    <= '0;
               err_full <= 1'b0;
            end else begin
               ptr   <= ptr + PTR_ONE;
               count <= count + CNT_ONE;
            end
         end
      end
   end

endmodule
